// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller:
// action/state codes, forward-select codes and register-match helpers.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MEM_WAIT  = 2'd1,
        RAW_STALL = 2'd2,
        FLUSH     = 2'd3
    } ctrl_state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

    // Memory-handshake tracker; MS_FORCED marks the cycle released by timeout.
    typedef enum logic [1:0] {
        MS_IDLE   = 2'd0,
        MS_WAIT   = 2'd1,
        MS_FORCED = 2'd2
    } mem_fsm_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a nonzero destination feeds one of the sources actually read.
    function automatic logic reads_reg(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (rd != REG_ZERO) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    function automatic fwd_sel_t fwd_select(input logic [4:0] src,
                                            input logic [4:0] exmem_rd, input logic exmem_we,
                                            input logic [4:0] memwb_rd, input logic memwb_we);
        if (src == REG_ZERO)
            return FWD_RF;
        if (exmem_we && (exmem_rd == src))
            return FWD_EXMEM;
        if (memwb_we && (memwb_rd == src))
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// ALU operand forwarding selects; the younger EX/MEM result wins over MEM/WB.
module pipeline_fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] exmem_rd,
    input  logic       exmem_regwrite,
    input  logic [4:0] memwb_rd,
    input  logic       memwb_regwrite,
    output fwd_sel_t   fwd_a,
    output fwd_sel_t   fwd_b
);

    always_comb begin
        fwd_a = fwd_select(ex_rs, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
        fwd_b = fwd_select(ex_rt, exmem_rd, exmem_regwrite, memwb_rd, memwb_regwrite);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline with perf counters.
// Build option: define FORWARDING_EN for operand forwarding with load-use-only stalls.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       idex_rd,
    input  logic             idex_regwrite,
    input  logic             idex_memread,
    input  logic [4:0]       exmem_rd,
    input  logic             exmem_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic             memwb_regwrite,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_err
);

    localparam int unsigned    WCW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    mem_fsm_t       mem_fsm;
    logic [WCW-1:0] wait_cnt;
    logic           mem_stall;
    logic           raw_hazard;
    ctrl_state_t    action;
    fwd_sel_t       sel_a;
    fwd_sel_t       sel_b;

    // The timeout-release cycle is treated as ready even if mem_ready stays low.
    assign mem_stall = mem_req & ~mem_ready & (mem_fsm != MS_FORCED);

`ifdef FORWARDING_EN
    pipeline_fwd_unit u_fwd (
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .exmem_rd       (exmem_rd),
        .exmem_regwrite (exmem_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_regwrite (memwb_regwrite),
        .fwd_a          (sel_a),
        .fwd_b          (sel_b)
    );

    assign raw_hazard = idex_memread & reads_reg(idex_rd, id_rs, id_rt, id_uses_rt);

    logic unused_cfg;
    assign unused_cfg = idex_regwrite;
`else
    assign sel_a = FWD_RF;
    assign sel_b = FWD_RF;

    // MEM/WB producers need no stall: the register file writes before it is read.
    assign raw_hazard = (idex_regwrite  & reads_reg(idex_rd,  id_rs, id_rt, id_uses_rt))
                      | (exmem_regwrite & reads_reg(exmem_rd, id_rs, id_rt, id_uses_rt));

    logic unused_cfg;
    assign unused_cfg = ^{idex_memread, ex_rs, ex_rt, memwb_rd, memwb_regwrite};
`endif

    always_comb begin
        if (mem_stall)
            action = MEM_WAIT;
        else if (ex_branch_taken)
            action = FLUSH;
        else if (raw_hazard)
            action = RAW_STALL;
        else
            action = RUN;
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        fwd_a        = sel_a;
        fwd_b        = sel_b;
        ctrl_state   = action;
        case (action)
            MEM_WAIT: begin
                pc_write     = 1'b0;
                ifid_write   = 1'b0;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end
            FLUSH: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end
            RAW_STALL: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_hold   = 1'b0;
            memwb_bubble = 1'b1;
            fwd_a        = FWD_RF;
            fwd_b        = FWD_RF;
            ctrl_state   = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_fsm     <= MS_IDLE;
            wait_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
            mem_err     <= 1'b0;
        end else begin
            if (mem_stall) begin
                if (wait_cnt == WAIT_LAST) begin
                    mem_fsm  <= MS_FORCED;
                    wait_cnt <= '0;
                    mem_err  <= 1'b1;
                end else begin
                    mem_fsm  <= MS_WAIT;
                    wait_cnt <= wait_cnt + WCW'(1);
                end
            end else begin
                mem_fsm  <= MS_IDLE;
                wait_cnt <= '0;
            end

            if (((action == MEM_WAIT) || (action == RAW_STALL)) && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
            if ((action == FLUSH) && (flush_count != '1))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
